jtag_uart_tx_sched: RTL and testbench
=====================================

JTAG_UART_TX_SCHED -- requirements
Module: jtag_uart_tx_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum bytes per grant before forced re-arbitration (1..255).
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester byte available.
REQ-006 SHALL have port req_data, input, 8*NUM_REQ, per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 SHALL have port req_last, input, NUM_REQ, marks the final byte of a requester message.
REQ-008 SHALL have port req_ready, output, NUM_REQ, one-hot byte-accept strobe.
REQ-009 SHALL have port av_chipselect, output, 1, Avalon-MM chipselect to the JTAG UART slave.
REQ-010 SHALL have port av_address, output, 1, 0 = data register, 1 = control register.
REQ-011 SHALL have ports av_read_n and av_write_n, output, 1 each, active-low strobes.
REQ-012 SHALL have port av_writedata, output, 32, with the byte in [7:0] and zeros in [31:8].
REQ-013 SHALL have ports av_readdata (input, 32) and av_waitrequest (input, 1).
REQ-014 SHALL have ports grant_id (output, 3, current owner) and busy (output, 1, high when the block is not in IDLE).

Function
REQ-015 SHALL implement the FSM states IDLE, POLL, WRITE and RELEASE.
REQ-016 IDLE SHALL, when any req_valid is high, select an owner by round-robin starting after the previous owner, then go to POLL.
REQ-017 POLL SHALL assert chipselect with address 1 and read_n low until waitrequest is low, then latch WSPACE = av_readdata[31:16] into wspace_cnt.
REQ-018 After POLL, the block SHALL go to WRITE if wspace_cnt is nonzero and SHALL otherwise repeat POLL on the next cycle.
REQ-019 WRITE SHALL present the owner's byte with address 0 and write_n low while req_valid[owner] is high, and SHALL hold the strobes and data stable while waitrequest is high.
REQ-020 The byte SHALL be accepted in the cycle where write_n is low and waitrequest is low; in that same cycle req_ready[owner] SHALL pulse for exactly one cycle, wspace_cnt SHALL decrement and burst_cnt SHALL increment.
REQ-021 WRITE SHALL go to RELEASE after an accepted byte if req_last was high, burst_cnt reached MAX_BURST, or req_valid[owner] was low in a cycle with no transfer pending.
REQ-022 WRITE SHALL go to POLL after an accepted byte when wspace_cnt becomes 0 and none of the REQ-021 conditions hold.
REQ-023 RELEASE SHALL deassert all strobes for one cycle, clear burst_cnt, record the owner as the round-robin pointer, and return to IDLE.
REQ-024 The block SHALL keep at most one Avalon transaction outstanding, and read_n and write_n SHALL never be low simultaneously.
REQ-025 req_ready SHALL never assert for a non-owner, and SHALL never assert outside WRITE.
REQ-026 If req_valid drops mid-message with no transfer pending, the grant SHALL release; no byte SHALL be duplicated or lost.
REQ-027 wspace_cnt SHALL be 16 bits and SHALL saturate at 0 without wrapping.
REQ-028 burst_cnt SHALL be 8 bits.
REQ-029 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.
REQ-030 Throughput SHALL be one byte per cycle when waitrequest is low and wspace is nonzero.

Reset
REQ-031 Reset SHALL place the FSM in IDLE, clear wspace_cnt and burst_cnt, set the round-robin pointer to NUM_REQ-1 (so requester 0 wins first), set grant_id to 0, and drive busy low.
REQ-032 During and after reset, av_chipselect SHALL be 0, av_read_n and av_write_n SHALL be 1, av_writedata SHALL be 0, and req_ready SHALL be all 0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no req_ready pulse in that cycle.

Structure
REQ-034 Shared package jtag_uart_pkg SHALL hold the register address constants (DATA=0, CTRL=1), the WSPACE field bit positions (31:16), and the FSM state enum.
REQ-035 The block SHALL contain one sub-module, rr_arbiter, a parameterized round-robin grant taking request vector and pointer and returning a one-hot grant plus index; everything else SHALL be flat.

Verification
REQ-036 Single requester 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), slave reports WSPACE=64, no waitrequest -> 1 control read, then 3 data writes on consecutive cycles, 3 req_ready pulses, then RELEASE.
REQ-037 All 4 requesters valid with 2-byte messages -> grants in order 0,1,2,3,0, with each message contiguous on the bus.
REQ-038 WSPACE=2 then 0 then 5, requester sends 4 bytes -> 2 writes, polls repeated until 5, then remaining 2 writes; no write issued while wspace_cnt=0.
REQ-039 MAX_BURST=16, requester streams 40 bytes with a competitor valid -> grant switches after bytes 16 and 32, interleaved with the competitor.
REQ-040 waitrequest held high 5 cycles on a write, then reset asserted on cycle 3 -> strobes go idle the next cycle, no req_ready pulse, busy=0.

Source files
------------

// File: rtl/jtag_uart_pkg.sv
// Shared definitions for the JTAG UART transmit scheduler: Avalon register map,
// WSPACE field location, FSM encoding and grant-index width.
package jtag_uart_pkg;
  localparam logic ADDR_DATA  = 1'b0;
  localparam logic ADDR_CTRL  = 1'b1;
  localparam int   WSPACE_MSB = 31;
  localparam int   WSPACE_LSB = 16;
  localparam int   IDX_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POLL,
    ST_WRITE,
    ST_RELEASE
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the first active request strictly after i_ptr wins,
// otherwise the lowest-numbered request at or below i_ptr.
module rr_arbiter
  import jtag_uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx
);
  logic             w_found_hi;
  logic             w_found_lo;
  logic [IDX_W-1:0] w_idx_hi;
  logic [IDX_W-1:0] w_idx_lo;

  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_idx_hi   = '0;
    w_idx_lo   = '0;
    o_grant    = '0;
    for (int j = 0; j < N; j++) begin
      if (i_req[j]) begin
        if (j > int'(i_ptr)) begin
          if (!w_found_hi) begin
            w_found_hi = 1'b1;
            w_idx_hi   = IDX_W'(j);
          end
        end else if (!w_found_lo) begin
          w_found_lo = 1'b1;
          w_idx_lo   = IDX_W'(j);
        end
      end
    end
    o_idx = w_found_hi ? w_idx_hi : w_idx_lo;
    for (int j = 0; j < N; j++) begin
      o_grant[j] = (w_found_hi || w_found_lo) && (o_idx == IDX_W'(j));
    end
  end
endmodule

// File: rtl/jtag_uart_tx_sched.sv
// Multiplexes several byte streams onto a JTAG UART Avalon-MM slave, polling
// WSPACE before writing and re-arbitrating after each message or burst.
module jtag_uart_tx_sched
  import jtag_uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 av_chipselect,
  output logic                 av_address,
  output logic                 av_read_n,
  output logic                 av_write_n,
  output logic [31:0]          av_writedata,
  input  logic [31:0]          av_readdata,
  input  logic                 av_waitrequest,
  output logic [2:0]           grant_id,
  output logic                 busy
);
  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_ptr;
  logic [15:0]      r_wspace;
  logic [7:0]       r_burst;
  logic             r_pend;
  logic [7:0]       r_pend_data;
  logic             r_pend_last;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic [7:0]         w_valid_ext;
  logic [7:0]         w_last_ext;
  logic [63:0]        w_data_ext;
  logic [7:0]         w_ready_ext;
  logic               w_wr_active;
  logic [7:0]         w_wr_data;
  logic               w_wr_last;
  logic               w_accept;
  logic               w_rd_done;
  logic [7:0]         w_burst_inc;
  logic               w_burst_hit;
  logic [15:0]        w_ws_rd;
  logic               w_unused;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_valid_ext = 8'(req_valid);
  assign w_last_ext  = 8'(req_last);
  assign w_data_ext  = 64'(req_data);
  assign w_ws_rd     = av_readdata[WSPACE_MSB:WSPACE_LSB];
  assign w_unused    = ^av_readdata[WSPACE_LSB-1:0];

  // Once a write has been stalled, the captured byte is replayed so the bus
  // stays stable even if the requester withdraws its valid.
  assign w_wr_active = (r_state == ST_WRITE) && (r_pend || w_valid_ext[r_owner]);
  assign w_wr_data   = r_pend ? r_pend_data : w_data_ext[{r_owner, 3'b000} +: 8];
  assign w_wr_last   = r_pend ? r_pend_last : w_last_ext[r_owner];
  assign w_accept    = w_wr_active && !av_waitrequest;
  assign w_rd_done   = (r_state == ST_POLL) && !av_waitrequest;
  assign w_burst_inc = r_burst + 8'd1;
  assign w_burst_hit = (w_burst_inc >= 8'(MAX_BURST));

  assign req_ready = w_ready_ext[NUM_REQ-1:0];
  assign grant_id  = r_owner;
  assign busy      = (r_state != ST_IDLE) && !reset;

  always_comb begin
    w_state_next  = r_state;
    av_chipselect = 1'b0;
    av_address    = ADDR_DATA;
    av_read_n     = 1'b1;
    av_write_n    = 1'b1;
    av_writedata  = 32'h0;
    w_ready_ext   = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (|w_grant) w_state_next = ST_POLL;
      end
      ST_POLL: begin
        av_chipselect = 1'b1;
        av_address    = ADDR_CTRL;
        av_read_n     = 1'b0;
        if (w_rd_done && (w_ws_rd != 16'h0)) w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (w_wr_active) begin
          av_chipselect = 1'b1;
          av_write_n    = 1'b0;
          av_writedata  = {24'h0, w_wr_data};
          if (!av_waitrequest) begin
            w_ready_ext[r_owner] = 1'b1;
            if (w_wr_last || w_burst_hit) w_state_next = ST_RELEASE;
            else if (r_wspace <= 16'd1)   w_state_next = ST_POLL;
          end
        end else begin
          w_state_next = ST_RELEASE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // Reset kills the bus in the same cycle it is seen.
    if (reset) begin
      av_chipselect = 1'b0;
      av_read_n     = 1'b1;
      av_write_n    = 1'b1;
      av_writedata  = 32'h0;
      w_ready_ext   = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_ptr       <= IDX_W'(NUM_REQ - 1);
      r_wspace    <= 16'h0;
      r_burst     <= 8'h0;
      r_pend      <= 1'b0;
      r_pend_data <= 8'h0;
      r_pend_last <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: if (|w_grant) r_owner <= w_idx;
        ST_POLL: if (w_rd_done) r_wspace <= w_ws_rd;
        ST_WRITE: begin
          if (w_wr_active && av_waitrequest && !r_pend) begin
            r_pend      <= 1'b1;
            r_pend_data <= w_wr_data;
            r_pend_last <= w_wr_last;
          end
          if (w_accept) begin
            r_pend   <= 1'b0;
            r_wspace <= (r_wspace != 16'h0) ? r_wspace - 16'd1 : 16'h0;
            r_burst  <= w_burst_inc;
          end
        end
        default: begin
          r_burst <= 8'h0;
          r_ptr   <= r_owner;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_uart_tx_sched.sv
// Directed bench for jtag_uart_tx_sched: requester queues, a WSPACE script for
// the slave, a per-cycle bus monitor and a write log.
module tb_jtag_uart_tx_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = 4'h0;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_last = 4'h0;
  logic [3:0]  req_ready;
  logic        av_chipselect, av_address, av_read_n, av_write_n;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata = 32'h0;
  logic        av_waitrequest;
  logic [2:0]  grant_id;
  logic        busy;

  logic tb_wait = 1'b0;
  logic tb_wait_on_write = 1'b0;
  assign av_waitrequest = tb_wait | (tb_wait_on_write & ~av_write_n);

  jtag_uart_tx_sched #(.NUM_REQ(4), .MAX_BURST(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .av_chipselect(av_chipselect),
    .av_address(av_address), .av_read_n(av_read_n), .av_write_n(av_write_n),
    .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cs;
    logic        addr;
    logic        rd_n;
    logic        wr_n;
    logic [31:0] wd;
    logic [3:0]  ready;
    logic        busy;
    logic [2:0]  gid;
  } snap_t;

  typedef struct packed {
    logic  wreq;
    snap_t exp;
  } vec_t;

  logic [8:0]  rmem [4][64];
  int          rhead [4];
  int          rtail [4];
  logic [15:0] ws_script [8];
  int          ws_idx = 0;
  int          ws_len = 1;
  int          m_ws = 0;
  int          poll_n = 0;
  int          viol = 0;
  logic [2:0]  log_id [128];
  logic [7:0]  log_d [128];
  int          log_n = 0;
  snap_t       snap [16];
  int          snap_n = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Requester and slave model: drive on the falling edge, observe 2 ns later.
  always @(negedge clk) begin
    logic [3:0] exp_ready;
    for (int i = 0; i < 4; i++) begin
      if (rhead[i] < rtail[i]) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = rmem[i][rhead[i]][7:0];
        req_last[i]         = rmem[i][rhead[i]][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
    av_readdata = {ws_script[ws_idx], 16'h0000};
    #2;
    if (snap_n < 16) begin
      snap[snap_n] = {av_chipselect, av_address, av_read_n, av_write_n,
                      av_writedata, req_ready, busy, grant_id};
      snap_n++;
    end
    if (!av_read_n && !av_write_n) viol++;
    if (av_chipselect && !av_read_n && !av_waitrequest) begin
      m_ws = int'(ws_script[ws_idx]);
      poll_n++;
      if (ws_idx < ws_len - 1) ws_idx++;
    end
    exp_ready = 4'h0;
    if (av_chipselect && !av_write_n && !av_waitrequest) begin
      if (m_ws == 0) viol++;
      else m_ws--;
      exp_ready = 4'h1 << grant_id;
      if (log_n < 128) begin
        log_id[log_n] = grant_id;
        log_d[log_n]  = av_writedata[7:0];
        log_n++;
      end
    end
    if (req_ready !== exp_ready) viol++;
    for (int i = 0; i < 4; i++) if (req_ready[i]) rhead[i]++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    rmem[r][rtail[r]] = {l, d};
    rtail[r]++;
  endtask

  task automatic set_ws(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input int n);
    ws_script[0] = a;
    ws_script[1] = b;
    ws_script[2] = c;
    ws_len = n;
    ws_idx = 0;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int c = 0;
    while (log_n < n && c < budget) begin
      step();
      c++;
    end
    check(name, 64'(log_n), 64'(n));
  endtask

  function automatic snap_t mk(input logic cs, input logic ad, input logic rd, input logic wr,
                               input logic [7:0] wd, input logic [3:0] rdy, input logic bz);
    return {cs, ad, rd, wr, {24'h0, wd}, rdy, bz, 3'd0};
  endfunction

  vec_t vecs [7];
  logic [2:0] exp_id [48];
  logic [7:0] exp_d [48];

  initial begin
    vecs[0] = {1'b0, mk(0, 0, 1, 1, 8'h00, 4'h0, 0)};
    vecs[1] = {1'b0, mk(1, 1, 0, 1, 8'h00, 4'h0, 1)};
    vecs[2] = {1'b0, mk(1, 0, 1, 0, 8'h41, 4'h1, 1)};
    vecs[3] = {1'b0, mk(1, 0, 1, 0, 8'h42, 4'h1, 1)};
    vecs[4] = {1'b0, mk(1, 0, 1, 0, 8'h43, 4'h1, 1)};
    vecs[5] = {1'b0, mk(0, 0, 1, 1, 8'h00, 4'h0, 1)};
    vecs[6] = {1'b0, mk(0, 0, 1, 1, 8'h00, 4'h0, 0)};
    for (int i = 0; i < 4; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    set_ws(16'd64, 16'd64, 16'd64, 1);

    // Reset state, while reset is held and after release.
    step(); step();
    check("rst_cs", 64'(av_chipselect), 64'd0);
    check("rst_rd_n", 64'(av_read_n), 64'd1);
    check("rst_wr_n", 64'(av_write_n), 64'd1);
    check("rst_wdata", 64'(av_writedata), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gid", 64'(grant_id), 64'd0);
    reset = 1'b0;
    step();
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_cs", 64'(av_chipselect), 64'd0);

    // Three-byte message from requester 0, compared cycle by cycle.
    push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
    snap_n = 0; viol = 0;
    for (int i = 0; i < 7; i++) begin
      tb_wait = vecs[i].wreq;
      step();
    end
    for (int i = 0; i < 7; i++) check($sformatf("t1_cyc%0d", i), 64'(snap[i]), 64'(vecs[i].exp));
    check("t1_drained", 64'(rhead[0]), 64'd3);

    // All four requesters: round-robin order 0,1,2,3,0 after a fresh reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    log_n = 0;
    push(0, 8'h10, 0); push(0, 8'h11, 1); push(0, 8'h12, 0); push(0, 8'h13, 1);
    push(1, 8'h20, 0); push(1, 8'h21, 1);
    push(2, 8'h30, 0); push(2, 8'h31, 1);
    push(3, 8'h40, 0); push(3, 8'h41, 1);
    exp_id[0] = 0; exp_d[0] = 8'h10; exp_id[1] = 0; exp_d[1] = 8'h11;
    exp_id[2] = 1; exp_d[2] = 8'h20; exp_id[3] = 1; exp_d[3] = 8'h21;
    exp_id[4] = 2; exp_d[4] = 8'h30; exp_id[5] = 2; exp_d[5] = 8'h31;
    exp_id[6] = 3; exp_d[6] = 8'h40; exp_id[7] = 3; exp_d[7] = 8'h41;
    exp_id[8] = 0; exp_d[8] = 8'h12; exp_id[9] = 0; exp_d[9] = 8'h13;
    wait_log(10, 200, "t2_count");
    for (int i = 0; i < 10; i++)
      check($sformatf("t2_w%0d", i), 64'({log_id[i], log_d[i]}), 64'({exp_id[i], exp_d[i]}));

    // WSPACE 2, then 0, then 5: requester 2 sends four bytes.
    set_ws(16'd2, 16'd0, 16'd5, 3);
    log_n = 0; poll_n = 0;
    push(2, 8'hA0, 0); push(2, 8'hA1, 0); push(2, 8'hA2, 0); push(2, 8'hA3, 1);
    wait_log(4, 100, "t3_count");
    step(); step(); step();
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_w%0d", i), 64'({log_id[i], log_d[i]}), 64'({3'd2, 8'hA0 + 8'(i)}));
    check("t3_polls", 64'(poll_n), 64'd3);
    check("t3_idle", 64'(busy), 64'd0);

    // 40-byte stream on requester 3 against two 1-byte messages on requester 0.
    set_ws(16'd64, 16'd64, 16'd64, 1);
    log_n = 0;
    for (int k = 0; k < 40; k++) push(3, 8'h80 + 8'(k), (k == 39));
    push(0, 8'hC1, 1); push(0, 8'hC2, 1);
    for (int k = 0; k < 16; k++) begin
      exp_id[k] = 3;      exp_d[k] = 8'h80 + 8'(k);
      exp_id[k + 17] = 3; exp_d[k + 17] = 8'h90 + 8'(k);
    end
    exp_id[16] = 0; exp_d[16] = 8'hC1;
    exp_id[33] = 0; exp_d[33] = 8'hC2;
    for (int k = 0; k < 8; k++) begin
      exp_id[34 + k] = 3; exp_d[34 + k] = 8'hA0 + 8'(k);
    end
    wait_log(42, 400, "t4_count");
    for (int i = 0; i < 42; i++)
      check($sformatf("t4_w%0d", i), 64'({log_id[i], log_d[i]}), 64'({exp_id[i], exp_d[i]}));

    // Stalled write abandoned by reset on the third wait cycle.
    step(); step(); step();
    log_n = 0;
    tb_wait_on_write = 1'b1;
    push(1, 8'h5A, 1);
    begin
      int c = 0;
      while (av_write_n !== 1'b0 && c < 20) begin
        step();
        c++;
      end
      check("t5_write_seen", 64'(av_write_n), 64'd0);
    end
    check("t5_c1_data", 64'(av_writedata), 64'h5A);
    check("t5_c1_ready", 64'(req_ready), 64'd0);
    step();
    check("t5_c2_data", 64'(av_writedata), 64'h5A);
    check("t5_c2_wr_n", 64'(av_write_n), 64'd0);
    step();
    reset = 1'b1;
    #1;
    check("t5_rst_cs", 64'(av_chipselect), 64'd0);
    check("t5_rst_wr_n", 64'(av_write_n), 64'd1);
    check("t5_rst_ready", 64'(req_ready), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    step();
    reset = 1'b0;
    #1;
    check("t5_after_busy", 64'(busy), 64'd0);
    check("t5_after_wr_n", 64'(av_write_n), 64'd1);
    check("t5_no_accept", 64'(log_n), 64'd0);
    tb_wait_on_write = 1'b0;
    wait_log(1, 50, "t5_resend");
    check("t5_byte", 64'({log_id[0], log_d[0]}), 64'({3'd1, 8'h5A}));

    check("bus_invariants", 64'(viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
